rmii_tx_framer: RTL and testbench

Final transmit stage of the Ethernet TX path. It consumes the LSB-first dibit stream produced by the bit-reordering stage, prepends the 802.3 preamble and SFD, and drives the RMII transmit pins (eth_txen, eth_txd). It also enforces the inter-packet gap. A FIFO absorbs the incoming frame while the 32-dibit preamble goes out, because the upstream stage has no backpressure.

---
 rtl/rmii_tx_framer.sv | 182 ++++++++++++++++++
 tb/tb_rmii_tx_framer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer
// Final transmit stage of the Ethernet TX path. Accepts the LSB-first dibit
// stream from the bit-reordering stage, prepends preamble + SFD, drives the
// RMII transmit pins and enforces the inter-packet gap. A dibit FIFO soaks up
// the incoming frame while the 32-dibit preamble is sent, because upstream
// cannot be stalled.
//
// Parameters:
//   FIFO_DEPTH  dibit FIFO entries (power of two, >= 33)
//   IPG_DIBITS  idle cycles after each frame (>= 2)
// Ports:
//   clk         RMII reference clock, one dibit per cycle
//   rst         synchronous active-high reset
//   axiiv       input dibit valid, contiguous for one frame
//   axiid       input dibit, LSB-first within each byte
//   eth_txen    RMII transmit enable
//   eth_txd     RMII transmit dibit
//   busy        high whenever the framer is not idle (registered, one cycle late)
//   frame_done  one-cycle pulse on the last IPG cycle
//   drop        one-cycle pulse when an input frame start is rejected
//   overflow    sticky FIFO overflow flag, cleared only by rst
module rmii_tx_framer #(
  parameter int FIFO_DEPTH = 64,
  parameter int IPG_DIBITS = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       eth_txen,
  output logic [1:0] eth_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       drop,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (IPG_DIBITS > 1) ? $clog2(IPG_DIBITS) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, IPG} state_t;

  state_t        state_q;
  logic [4:0]    preCnt_q;
  logic [IW-1:0] ipgCnt_q;
  logic          ended_q;
  logic          armed_q;

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;

  logic fifoEmpty, fifoFull;
  logic startFrame, capture, wrReq, wrEn, rdEn, reject, inFrame;
  logic [1:0] rdData;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign rdData    = mem_q[rdPtr_q[AW-1:0]];

  // Write/read decisions for this cycle. A start is only honoured while armed,
  // so the tail of a rejected or reset-interrupted frame cannot look like a
  // new frame. Rejection is gated by armed_q so one burst pulses drop once.
  always_comb begin
    inFrame    = (state_q == PREAMBLE) || (state_q == DATA);
    startFrame = (state_q == IDLE) && axiiv && armed_q;
    capture    = inFrame && !ended_q && axiiv;
    wrReq      = startFrame || capture;
    wrEn       = wrReq && !fifoFull;
    rdEn       = (state_q == DATA) && !fifoEmpty;
    reject     = axiiv && armed_q &&
                 ((inFrame && ended_q) || (state_q == IPG));
    wrPtr_d    = wrEn ? wrPtr_q + PTR_ONE : wrPtr_q;
    rdPtr_d    = rdEn ? rdPtr_q + PTR_ONE : rdPtr_q;
  end

  // FIFO storage has no reset; a flush is done by clearing the pointers.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wrPtr_q[AW-1:0]] <= axiid;
    end
  end

  // Framer FSM with registered outputs. busy follows the state one cycle late
  // so it rises with the first preamble dibit and falls after frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      preCnt_q   <= '0;
      ipgCnt_q   <= '0;
      ended_q    <= 1'b0;
      armed_q    <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      eth_txen   <= 1'b0;
      eth_txd    <= 2'b00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      frame_done <= 1'b0;
      drop       <= reject;
      busy       <= (state_q != IDLE);

      if (wrReq && fifoFull) begin
        overflow <= 1'b1;
      end

      if (reject) begin
        armed_q <= 1'b0;
      end else if (!axiiv) begin
        armed_q <= 1'b1;
      end

      if (inFrame && !axiiv) begin
        ended_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          ended_q  <= 1'b0;
          eth_txen <= 1'b0;
          eth_txd  <= 2'b00;
          if (startFrame) begin
            preCnt_q <= '0;
            state_q  <= PREAMBLE;
          end
        end

        // 31 dibits of 01 then a single 11 forms 7x 0x55 followed by 0xD5.
        PREAMBLE: begin
          eth_txen <= 1'b1;
          if (preCnt_q == 5'd31) begin
            eth_txd <= 2'b11;
            state_q <= DATA;
          end else begin
            eth_txd  <= 2'b01;
            preCnt_q <= preCnt_q + 5'd1;
          end
        end

        // An empty FIFO before the input has ended can only happen with a
        // gapped upstream stream; keep txen up and send zeros meanwhile.
        DATA: begin
          if (!fifoEmpty) begin
            eth_txen <= 1'b1;
            eth_txd  <= rdData;
          end else if (ended_q) begin
            eth_txen <= 1'b0;
            eth_txd  <= 2'b00;
            ipgCnt_q <= IW'(1);
            state_q  <= IPG;
          end else begin
            eth_txen <= 1'b1;
            eth_txd  <= 2'b00;
          end
        end

        // The DATA exit cycle is the first gap cycle, so counting starts at 1.
        IPG: begin
          eth_txen <= 1'b0;
          eth_txd  <= 2'b00;
          if (ipgCnt_q == IW'(IPG_DIBITS - 1)) begin
            frame_done <= 1'b1;
            state_q    <= IDLE;
          end else begin
            ipgCnt_q <= ipgCnt_q + IW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_tx_framer.sv
// tb_rmii_tx_framer
// Scoreboard bench for rmii_tx_framer. Each accepted frame pushes its
// expected txd dibits, txen rise/fall cycles and frame_done cycle into
// queues; a monitor pops and compares them as the DUT produces output.
module tb_rmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic       eth_txen;
  logic [1:0] eth_txd;
  logic       busy;
  logic       frame_done;
  logic       drop;
  logic       overflow;

  rmii_tx_framer #(.FIFO_DEPTH(64), .IPG_DIBITS(48)) dut (
    .clk(clk),
    .rst(rst),
    .axiiv(axiiv),
    .axiid(axiid),
    .eth_txen(eth_txen),
    .eth_txd(eth_txd),
    .busy(busy),
    .frame_done(frame_done),
    .drop(drop),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int dropCount   = 0;
  int expDrop     = 0;

  logic [1:0] dQ[$];
  int         riseQ[$];
  int         fallQ[$];
  int         doneQ[$];
  logic [1:0] frameData[$];

  logic prevTxen = 1'b0;
  logic prevDone = 1'b0;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // Cycle n is the clock edge at which the DUT samples inputs and updates
  // its registered outputs.
  always @(posedge clk) cyc++;

  // Output monitor, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prevTxen = eth_txen;
      prevDone = 1'b0;
    end else begin
      if (prevDone) checkOutput("busy_after_done", 32'(busy), 0);
      if (eth_txen && !prevTxen && riseQ.size() > 0) begin
        checkOutput("txen_rise", cyc, riseQ.pop_front());
        checkOutput("busy_at_rise", 32'(busy), 1);
      end
      if (eth_txen) begin
        if (dQ.size() == 0) checkOutput("unexpected_txen", 32'(eth_txen), 0);
        else checkOutput("txd", 32'(eth_txd), 32'(dQ.pop_front()));
      end
      if (!eth_txen && prevTxen) begin
        checkOutput("txd_idle", 32'(eth_txd), 0);
        if (fallQ.size() > 0) checkOutput("txen_fall", cyc, fallQ.pop_front());
      end
      if (frame_done) begin
        if (doneQ.size() == 0) checkOutput("unexpected_done", 32'(frame_done), 0);
        else begin
          checkOutput("frame_done", cyc, doneQ.pop_front());
          checkOutput("busy_at_done", 32'(busy), 1);
        end
      end
      if (drop) dropCount++;
      prevTxen = eth_txen;
      prevDone = frame_done;
    end
  end

  // Expected output for a frame whose first dibit is driven at the negedge
  // where cyc == c (sampled at edge c+1, i.e. frame cycle 0).
  task automatic pushFrameExpect(input int c);
    int len;
    len = frameData.size();
    riseQ.push_back(c + 2);
    fallQ.push_back(c + len + 34);
    doneQ.push_back(c + len + 81);
    for (int i = 0; i < 31; i++) dQ.push_back(2'b01);
    dQ.push_back(2'b11);
    for (int i = 0; i < len; i++) dQ.push_back(frameData[i]);
  endtask

  // Drives frameData contiguously; called at a negedge.
  task automatic applyStimulus(input bit expectTx);
    if (expectTx) pushFrameExpect(cyc);
    for (int i = 0; i < frameData.size(); i++) begin
      axiiv = 1'b1;
      axiid = frameData[i];
      @(negedge clk);
    end
    axiiv = 1'b0;
    axiid = 2'b00;
  endtask

  task automatic buildIncrement(input int nBytes);
    logic [7:0] b;
    frameData.delete();
    for (int i = 0; i < nBytes; i++) begin
      b = 8'(i);
      frameData.push_back(b[1:0]);
      frameData.push_back(b[3:2]);
      frameData.push_back(b[5:4]);
      frameData.push_back(b[7:6]);
    end
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while ((doneQ.size() != 0 || dQ.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_done_pending", doneQ.size() + dQ.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int fall;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_txen", 32'(eth_txen), 0);
    checkOutput("rst_txd", 32'(eth_txd), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_drop", 32'(drop), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte frame.
    $display("[TB] single byte frame");
    frameData = '{2'b01, 2'b00, 2'b11, 2'b10};
    applyStimulus(1'b1);
    waitDone(200);
    checkOutput("single_overflow", 32'(overflow), 0);

    // 60-byte frame of incrementing bytes.
    $display("[TB] long frame");
    buildIncrement(60);
    applyStimulus(1'b1);
    waitDone(400);
    checkOutput("long_drop_count", dropCount, expDrop);

    // IPG violation: rogue burst starts 10 cycles after txen falls and runs
    // on past the end of the gap; it must never be transmitted.
    $display("[TB] ipg violation");
    c0 = cyc;
    buildIncrement(2);
    applyStimulus(1'b1);
    fall = c0 + frameData.size() + 34;
    while (cyc < fall + 9) @(negedge clk);
    buildIncrement(15);
    applyStimulus(1'b0);
    expDrop++;
    waitDone(200);
    checkOutput("ipg_drop_count", dropCount, expDrop);
    buildIncrement(3);
    applyStimulus(1'b1);
    waitDone(200);
    checkOutput("ipg_third_drop_count", dropCount, expDrop);

    // Reset in the middle of DATA of a 240-dibit frame.
    $display("[TB] reset mid-data");
    buildIncrement(60);
    pushFrameExpect(cyc);
    for (int k = 0; k < 240; k++) begin
      if (k == 50) begin
        rst = 1'b1;
        dQ.delete();
        fallQ.delete();
        doneQ.delete();
      end
      if (k == 51) begin
        checkOutput("midrst_txen", 32'(eth_txen), 0);
        checkOutput("midrst_txd", 32'(eth_txd), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
      end
      axiiv = 1'b1;
      axiid = frameData[k];
      @(negedge clk);
    end
    axiiv = 1'b0;
    axiid = 2'b00;
    repeat (3) @(negedge clk);
    buildIncrement(4);
    applyStimulus(1'b1);
    waitDone(200);
    checkOutput("midrst_drop_count", dropCount, expDrop);

    // Back-to-back at the minimum gap.
    $display("[TB] back-to-back");
    c0 = cyc;
    buildIncrement(2);
    applyStimulus(1'b1);
    while (cyc < c0 + frameData.size() + 81) @(negedge clk);
    buildIncrement(5);
    applyStimulus(1'b1);
    waitDone(300);
    checkOutput("b2b_drop_count", dropCount, expDrop);

    // axiiv held high across reset release: nothing may be sent until it
    // has gone low and risen again.
    $display("[TB] armed check");
    axiiv = 1'b1;
    axiid = 2'b01;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    axiiv = 1'b0;
    axiid = 2'b00;
    @(negedge clk);
    checkOutput("armed_quiet_txen", 32'(eth_txen), 0);
    frameData = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};
    applyStimulus(1'b1);
    waitDone(200);
    checkOutput("armed_drop_count", dropCount, expDrop);

    checkOutput("final_overflow", 32'(overflow), 0);
    checkOutput("final_queues_empty",
                dQ.size() + riseQ.size() + fallQ.size() + doneQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
